instr_fetch_ctrl: RTL and testbench
===================================

# instr_fetch_ctrl

Instruction fetch sequencer for the single-cycle MIPS-subset core. Owns the program counter, drives the word address of the combinational instruction memory, and registers each fetched word into a one-entry output stage with a valid/ready handshake toward decode. It supports start/done sequencing over a bounded program, branch/jump redirect with flush, and a freeze input.

## Interface
- AW, 8, instruction memory word-address width.
- RESET_PC, 0, first fetch address after start.
- LAST_ADDR, 4, final program address; fetching stops after this word is captured.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; honoured only in IDLE or DONE.
- imem_addr  out  AW  word address to instruction memory.
- imem_rd  in  32  instruction word, combinational from imem_addr.
- instr  out  32  registered instruction to decode.
- instr_pc  out  AW  address of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decode accepts; transfer when valid && ready.
- redirect  in  1  single-cycle pulse; flush and refetch from redirect_pc.
- redirect_pc  in  AW  redirect target.
- halt_req  in  1  level; freezes new captures.
- busy  out  1  high in FETCH or DRAIN.
- done  out  1  high in DONE.
- fetch_cnt  out  AW+1  handshakes completed since the last accepted start.

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- Reset (async, rst_n low): state IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, fetch_cnt=0. busy=0 and done=0.
- imem_addr = pc, combinationally, in all states.
- IDLE/DONE + start: pc<=RESET_PC, instr_valid<=0, fetch_cnt<=0, go to FETCH.
- FETCH capture condition: !halt_req && (!instr_valid || instr_ready).
  - On capture: instr<=imem_rd, instr_pc<=pc, instr_valid<=1.
  - If pc==LAST_ADDR, go to DRAIN with pc unchanged. Otherwise pc<=pc+1, wrapping modulo 2^AW.
- FETCH with no capture because instr_valid && !instr_ready: all output registers hold (stall), and pc holds.
- Handshake (instr_valid && instr_ready) with no new capture: instr_valid<=0.
- DRAIN: no captures. When the final word is handshaken, instr_valid<=0 and the state goes to DONE.
- Each handshake increments fetch_cnt, in any state. A redirect in the same cycle as a handshake still counts it.
- Redirect is honoured only in FETCH and DRAIN and has priority over capture and halt_req.
  - It clears instr_valid and discards the current word, even if the same cycle handshakes.
  - If redirect_pc <= LAST_ADDR: pc<=redirect_pc, go to FETCH.
  - If redirect_pc > LAST_ADDR: go to DONE.
- Redirect in IDLE or DONE is ignored. If start and redirect arrive in the same IDLE/DONE cycle, start wins.
- halt_req blocks captures only. Handshakes and redirects still apply. Releasing halt_req resumes capture on the next edge.
- start in FETCH or DRAIN is ignored.

## Timing
- First word: start sampled at edge k gives pc=RESET_PC after k, and instr_valid=1 with instr=mem[RESET_PC] after edge k+1.
- Throughput: 1 instruction per cycle while instr_ready=1 and halt_req=0.
- Redirect at edge r: instr_valid=0 after r. The word at redirect_pc is valid after r+1.
- done rises on the edge that completes the final handshake.
- busy and done are decoded from the state register only, with no combinational input paths.

## Test plan
- Bench memory image: 0:0x20010003, 1:0x20020009, 2:0x00221020, 3:0x00221824, 4:0x00222025.
  - start with ready=1 -> instr_pc 0,1,2,3,4 on five consecutive cycles, words as listed. done=1 on the edge after pc 4 is accepted, fetch_cnt=5.
- Backpressure: ready=0 for 3 cycles while instr_pc=2 -> instr holds 0x00221020 and imem_addr holds 3. Release -> instr_pc 3 appears next cycle with nothing skipped or duplicated.
- Redirect pulse with redirect_pc=1 while instr_pc=3 is valid -> instr_valid=0 next cycle, then instr_pc 1,2,3,4 follow. Redirect_pc=7 instead -> DONE with instr_valid=0.
- halt_req high for 4 cycles in FETCH with ready=1 -> pending word drains, no new captures, pc frozen. Capture resumes one edge after release.
- rst_n low mid-run at instr_pc=2 -> outputs zero immediately (asynchronous), state IDLE, imem_addr=0. start afterwards restarts at pc 0.
- Ignored events: start during FETCH -> sequence unaffected. Redirect in DONE -> stays DONE. start and redirect together in DONE -> restart at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl
//
// Instruction fetch sequencer for the single-cycle MIPS-subset core. It owns
// the program counter, addresses a combinational instruction memory, and
// registers each fetched word into a one-entry output stage that is handed
// to decode with a valid/ready handshake. A run starts with `start`, fetches
// RESET_PC..LAST_ADDR, and ends in DONE once the final word is accepted.
// Branch/jump redirects flush the output stage and refetch. `halt_req`
// freezes new captures.
//
// Ports:
//   clk          in   1     system clock, rising edge
//   rst_n        in   1     asynchronous active-low reset
//   start        in   1     begin a run (only from IDLE or DONE)
//   imem_addr    out  AW    word address to instruction memory (= pc)
//   imem_rd      in   32    instruction word, combinational from imem_addr
//   instr        out  32    registered instruction to decode
//   instr_pc     out  AW    address of instr
//   instr_valid  out  1     instr/instr_pc valid
//   instr_ready  in   1     decode accepts (transfer on valid && ready)
//   redirect     in   1     single-cycle flush/refetch pulse
//   redirect_pc  in   AW    redirect target
//   halt_req     in   1     level, blocks new captures
//   busy         out  1     high in FETCH or DRAIN
//   done         out  1     high in DONE
//   fetch_cnt    out  AW+1  handshakes completed since last accepted start
// ---------------------------------------------------------------------------
module instr_fetch_ctrl #(
    parameter int AW        = 8,
    parameter int RESET_PC  = 0,
    parameter int LAST_ADDR = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rd,
    output logic [31:0]   instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    input  logic          halt_req,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] START_PC = RESET_PC[AW-1:0];
    localparam logic [AW-1:0] LAST_PC  = LAST_ADDR[AW-1:0];
    localparam logic [AW-1:0] PC_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic [AW-1:0] instr_pc_q, instr_pc_d;
    logic          valid_q, valid_d;
    logic [AW:0]   cnt_q, cnt_d;

    logic handshake;
    logic capture_ok;

    assign handshake  = valid_q && instr_ready;
    // The output slot is free when empty or being emptied this cycle.
    assign capture_ok = !halt_req && (!valid_q || instr_ready);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= START_PC;
            instr_q    <= 32'h0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic. Redirect outranks capture and halt; the handshake
    // counter advances independently of whatever else happens that cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;

        if (handshake) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    pc_d    = START_PC;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = FETCH;
                end else if (handshake) begin
                    valid_d = 1'b0;
                end
            end

            FETCH: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    if (redirect_pc <= LAST_PC) begin
                        pc_d    = redirect_pc;
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end else if (capture_ok) begin
                    instr_d    = imem_rd;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    if (pc_q == LAST_PC) begin
                        state_d = DRAIN;
                    end else begin
                        pc_d = pc_q + PC_ONE;
                    end
                end else if (handshake) begin
                    valid_d = 1'b0;
                end
            end

            DRAIN: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    if (redirect_pc <= LAST_PC) begin
                        pc_d    = redirect_pc;
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end else if (handshake) begin
                    valid_d = 1'b0;
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign fetch_cnt   = cnt_q;
    // Status flags come straight from the state register, no input paths.
    assign busy        = (state_q == FETCH) || (state_q == DRAIN);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_ctrl
//
// Directed testbench for instr_fetch_ctrl with a five-word program image.
// Each scenario task drives inputs 1 time unit after a rising edge and
// checks outputs at the same point, against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_instr_fetch_ctrl;

    localparam int AW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rd;
    logic [31:0]   instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          halt_req;
    logic          busy;
    logic          done;
    logic [AW:0]   fetch_cnt;

    logic [31:0] mem [0:4];

    int pass_cnt;
    int total_cnt;

    instr_fetch_ctrl #(.AW(AW), .RESET_PC(0), .LAST_ADDR(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_req    (halt_req),
        .busy        (busy),
        .done        (done),
        .fetch_cnt   (fetch_cnt)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Combinational instruction memory.
    assign imem_rd = (imem_addr <= 8'd4) ? mem[imem_addr[2:0]] : 32'h0;

    // Advance one cycle, landing 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total_cnt++; if (instr_valid !== 1'b0) $display("[TB] FAIL rst_valid got %0b exp 0", instr_valid); else pass_cnt++;
        total_cnt++; if (instr !== 32'h0 || instr_pc !== 8'd0) $display("[TB] FAIL rst_instr got %h/%0d exp 0/0", instr, instr_pc); else pass_cnt++;
        total_cnt++; if (fetch_cnt !== 9'd0 || imem_addr !== 8'd0) $display("[TB] FAIL rst_cnt_addr got %0d/%0d exp 0/0", fetch_cnt, imem_addr); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL rst_flags got busy=%0b done=%0b exp 0/0", busy, done); else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_sequence();
        instr_ready = 1'b1;
        do_start();
        total_cnt++; if (busy !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 8'd0) $display("[TB] FAIL seq_start got busy=%0b valid=%0b addr=%0d exp 1/0/0", busy, instr_valid, imem_addr); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            step();
            total_cnt++; if (instr_valid !== 1'b1 || instr_pc !== i[7:0]) $display("[TB] FAIL seq_pc%0d got valid=%0b pc=%0d exp 1/%0d", i, instr_valid, instr_pc, i); else pass_cnt++;
            total_cnt++; if (instr !== mem[i]) $display("[TB] FAIL seq_word%0d got %h exp %h", i, instr, mem[i]); else pass_cnt++;
            total_cnt++; if (imem_addr !== ((i < 4) ? i[7:0] + 8'd1 : 8'd4)) $display("[TB] FAIL seq_addr%0d got %0d", i, imem_addr); else pass_cnt++;
        end
        step();
        total_cnt++; if (done !== 1'b1 || busy !== 1'b0 || instr_valid !== 1'b0) $display("[TB] FAIL seq_done got done=%0b busy=%0b valid=%0b exp 1/0/0", done, busy, instr_valid); else pass_cnt++;
        total_cnt++; if (fetch_cnt !== 9'd5) $display("[TB] FAIL seq_cnt got %0d exp 5", fetch_cnt); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b1;
        do_start();
        step(); step(); step();
        total_cnt++; if (instr_pc !== 8'd2) $display("[TB] FAIL bp_setup got pc=%0d exp 2", instr_pc); else pass_cnt++;
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++; if (instr !== 32'h00221020 || instr_pc !== 8'd2 || instr_valid !== 1'b1) $display("[TB] FAIL bp_hold%0d got %h pc=%0d valid=%0b exp 00221020/2/1", i, instr, instr_pc, instr_valid); else pass_cnt++;
            total_cnt++; if (imem_addr !== 8'd3) $display("[TB] FAIL bp_addr%0d got %0d exp 3", i, imem_addr); else pass_cnt++;
        end
        instr_ready = 1'b1;
        step();
        total_cnt++; if (instr_pc !== 8'd3 || instr !== 32'h00221824 || instr_valid !== 1'b1) $display("[TB] FAIL bp_release got pc=%0d %h exp 3/00221824", instr_pc, instr); else pass_cnt++;
        step();
        total_cnt++; if (instr_pc !== 8'd4) $display("[TB] FAIL bp_next got pc=%0d exp 4", instr_pc); else pass_cnt++;
        step();
        total_cnt++; if (done !== 1'b1 || fetch_cnt !== 9'd5) $display("[TB] FAIL bp_done got done=%0b cnt=%0d exp 1/5", done, fetch_cnt); else pass_cnt++;
    endtask

    task automatic test_redirect();
        instr_ready = 1'b1;
        do_start();
        step(); step(); step(); step();
        total_cnt++; if (instr_pc !== 8'd3 || instr_valid !== 1'b1) $display("[TB] FAIL rd_setup got pc=%0d valid=%0b exp 3/1", instr_pc, instr_valid); else pass_cnt++;
        redirect    = 1'b1;
        redirect_pc = 8'd1;
        step();
        redirect = 1'b0;
        total_cnt++; if (instr_valid !== 1'b0 || imem_addr !== 8'd1 || busy !== 1'b1) $display("[TB] FAIL rd_flush got valid=%0b addr=%0d busy=%0b exp 0/1/1", instr_valid, imem_addr, busy); else pass_cnt++;
        total_cnt++; if (fetch_cnt !== 9'd4) $display("[TB] FAIL rd_cnt_hs got %0d exp 4", fetch_cnt); else pass_cnt++;
        for (int i = 1; i < 5; i++) begin
            step();
            total_cnt++; if (instr_valid !== 1'b1 || instr_pc !== i[7:0] || instr !== mem[i]) $display("[TB] FAIL rd_refetch%0d got valid=%0b pc=%0d %h", i, instr_valid, instr_pc, instr); else pass_cnt++;
        end
        step();
        total_cnt++; if (done !== 1'b1 || fetch_cnt !== 9'd8) $display("[TB] FAIL rd_done got done=%0b cnt=%0d exp 1/8", done, fetch_cnt); else pass_cnt++;

        do_start();
        step(); step(); step(); step();
        redirect    = 1'b1;
        redirect_pc = 8'd7;
        step();
        redirect = 1'b0;
        total_cnt++; if (done !== 1'b1 || busy !== 1'b0 || instr_valid !== 1'b0) $display("[TB] FAIL rd_out got done=%0b busy=%0b valid=%0b exp 1/0/0", done, busy, instr_valid); else pass_cnt++;
        total_cnt++; if (fetch_cnt !== 9'd4) $display("[TB] FAIL rd_out_cnt got %0d exp 4", fetch_cnt); else pass_cnt++;
    endtask

    task automatic test_halt();
        instr_ready = 1'b1;
        do_start();
        step();
        halt_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total_cnt++; if (instr_valid !== 1'b0 || imem_addr !== 8'd1) $display("[TB] FAIL halt_frz%0d got valid=%0b addr=%0d exp 0/1", i, instr_valid, imem_addr); else pass_cnt++;
        end
        halt_req = 1'b0;
        step();
        total_cnt++; if (instr_valid !== 1'b1 || instr_pc !== 8'd1 || instr !== 32'h20020009) $display("[TB] FAIL halt_resume got valid=%0b pc=%0d %h exp 1/1/20020009", instr_valid, instr_pc, instr); else pass_cnt++;
        step(); step(); step(); step();
        total_cnt++; if (done !== 1'b1 || fetch_cnt !== 9'd5) $display("[TB] FAIL halt_done got done=%0b cnt=%0d exp 1/5", done, fetch_cnt); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        instr_ready = 1'b1;
        do_start();
        step(); step(); step();
        total_cnt++; if (instr_pc !== 8'd2) $display("[TB] FAIL ar_setup got pc=%0d exp 2", instr_pc); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 8'd0 || imem_addr !== 8'd0) $display("[TB] FAIL ar_zero got valid=%0b %h pc=%0d addr=%0d exp 0", instr_valid, instr, instr_pc, imem_addr); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0 || fetch_cnt !== 9'd0) $display("[TB] FAIL ar_idle got busy=%0b done=%0b cnt=%0d exp 0/0/0", busy, done, fetch_cnt); else pass_cnt++;
        #2;
        rst_n = 1'b1;
        step();
        do_start();
        step();
        total_cnt++; if (instr_valid !== 1'b1 || instr_pc !== 8'd0 || instr !== 32'h20010003) $display("[TB] FAIL ar_restart got valid=%0b pc=%0d %h exp 1/0/20010003", instr_valid, instr_pc, instr); else pass_cnt++;
    endtask

    task automatic test_ignored();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        instr_ready = 1'b1;
        do_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        total_cnt++; if (instr_pc !== 8'd1 || imem_addr !== 8'd2 || busy !== 1'b1) $display("[TB] FAIL ign_start got pc=%0d addr=%0d busy=%0b exp 1/2/1", instr_pc, imem_addr, busy); else pass_cnt++;
        step(); step(); step(); step();
        total_cnt++; if (done !== 1'b1 || fetch_cnt !== 9'd5) $display("[TB] FAIL ign_done got done=%0b cnt=%0d exp 1/5", done, fetch_cnt); else pass_cnt++;
        redirect    = 1'b1;
        redirect_pc = 8'd2;
        step();
        redirect = 1'b0;
        total_cnt++; if (done !== 1'b1 || imem_addr !== 8'd4 || fetch_cnt !== 9'd5) $display("[TB] FAIL ign_redir got done=%0b addr=%0d cnt=%0d exp 1/4/5", done, imem_addr, fetch_cnt); else pass_cnt++;
        start       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 8'd2;
        step();
        start    = 1'b0;
        redirect = 1'b0;
        total_cnt++; if (busy !== 1'b1 || imem_addr !== 8'd0 || fetch_cnt !== 9'd0) $display("[TB] FAIL ign_both got busy=%0b addr=%0d cnt=%0d exp 1/0/0", busy, imem_addr, fetch_cnt); else pass_cnt++;
        step();
        total_cnt++; if (instr_pc !== 8'd0 || instr_valid !== 1'b1) $display("[TB] FAIL ign_both_word got pc=%0d valid=%0b exp 0/1", instr_pc, instr_valid); else pass_cnt++;
    endtask

    // Scenario sequence.
    initial begin
        mem[0] = 32'h20010003;
        mem[1] = 32'h20020009;
        mem[2] = 32'h00221020;
        mem[3] = 32'h00221824;
        mem[4] = 32'h00222025;
        pass_cnt    = 0;
        total_cnt   = 0;
        start       = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        halt_req    = 1'b0;
        rst_n       = 1'b1;
        #1;

        test_reset();
        test_sequence();
        test_backpressure();
        test_redirect();
        test_halt();
        test_async_reset();
        test_ignored();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
